// File: rtl/shift64_seq_pkg.sv
// Shared definitions for the 64-bit shift sequencer.
// Contents:
//   SQ_DW / SQ_AW / SQ_NW : data word, 64-bit amount and shifter amount widths
//   SH_LEFT/SH_LRIGHT/SH_ARIGHT : shifter control encodings (Shiftctr)
//   sq_state_t            : sequencer state encoding
//   pass_t / pass_plan()  : what the external shifter is fed in a given pass
package shift64_seq_pkg;

    localparam int SQ_DW = 32;
    localparam int SQ_AW = 6;
    localparam int SQ_NW = 5;

    localparam logic [1:0] SH_LEFT   = 2'b00;
    localparam logic [1:0] SH_LRIGHT = 2'b10;
    localparam logic [1:0] SH_ARIGHT = 2'b11;

    typedef enum logic [2:0] {
        SQ_IDLE = 3'd0,
        SQ_P0   = 3'd1,
        SQ_P1   = 3'd2,
        SQ_P2   = 3'd3,
        SQ_DONE = 3'd4
    } sq_state_t;

    // One shifter pass: operand, amount, control, and which accumulator
    // word the result is ORed into.
    typedef struct packed {
        logic [SQ_DW-1:0] indata;
        logic [SQ_NW-1:0] num;
        logic [1:0]       ctr;
        logic             to_hi;
    } pass_t;

    // Pass plan for a {hi,lo} shift by amt.
    //   amt >= 32 : single pass by k = amt-32 moving one word across.
    //   amt 1..31 : three passes; the word crossing the 32-bit boundary is
    //               produced by shifting the opposite way by m = 32-n.
    // States without a pass return all zeros so the shifter sees 0.
    function automatic pass_t pass_plan(input sq_state_t        st,
                                        input logic [1:0]       op,
                                        input logic [SQ_AW-1:0] amt,
                                        input logic [SQ_DW-1:0] hi,
                                        input logic [SQ_DW-1:0] lo);
        pass_t            p;
        logic             is_left;
        logic             wide;
        logic [SQ_NW-1:0] n;
        logic [SQ_NW-1:0] m;
        is_left = ~op[1];
        wide    = amt[SQ_AW-1];
        n       = amt[SQ_NW-1:0];
        // 32-n wraps correctly in 5 bits because n is never 0 here.
        m       = 5'd0 - n;
        p       = '0;
        case (st)
            SQ_P0: begin
                p.indata = (wide && is_left) ? lo : hi;
                p.num    = n;
                p.ctr    = is_left ? SH_LEFT : op;
                p.to_hi  = wide ? is_left : 1'b1;
            end
            SQ_P1: begin
                p.indata = is_left ? lo : hi;
                p.num    = m;
                p.ctr    = is_left ? SH_LRIGHT : SH_LEFT;
                p.to_hi  = is_left;
            end
            SQ_P2: begin
                p.indata = lo;
                p.num    = n;
                p.ctr    = is_left ? SH_LEFT : SH_LRIGHT;
                p.to_hi  = 1'b0;
            end
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/shift64_seq.sv
// 64-bit {hi,lo} shift sequencer. Time-multiplexes the pipeline's external
// 32-bit combinational barrel shifter over 1-3 passes and ORs the partial
// results into hi/lo accumulators.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort of any request / pending response
//   req_valid/req_ready   request handshake; req_op, req_amt, req_hi, req_lo
//   resp_valid/resp_ready response handshake; resp_hi, resp_lo
//   sh_indata/sh_num/sh_ctr  drive the external shifter
//   sh_result             combinational result from the external shifter
//   state_dbg             current sequencer state (observation only)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE. resp_valid is high only in DONE
// and stays high with stable resp_hi/resp_lo until resp_ready is seen.
module shift64_seq
    import shift64_seq_pkg::*;
#(
    parameter int DW = SQ_DW,
    parameter int AW = SQ_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [AW-1:0]   req_amt,
    input  logic [DW-1:0]   req_hi,
    input  logic [DW-1:0]   req_lo,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [DW-1:0]   resp_hi,
    output logic [DW-1:0]   resp_lo,
    output logic [DW-1:0]   sh_indata,
    output logic [SQ_NW-1:0] sh_num,
    output logic [1:0]      sh_ctr,
    input  logic [DW-1:0]   sh_result,
    output sq_state_t       state_dbg
);

    sq_state_t       state;
    sq_state_t       state_nxt;
    logic [1:0]      op_q;
    logic [AW-1:0]   amt_q;
    logic [DW-1:0]   hi_q;
    logic [DW-1:0]   lo_q;
    logic [DW-1:0]   acc_hi;
    logic [DW-1:0]   acc_lo;
    pass_t           plan;

    assign plan = pass_plan(state, op_q, amt_q, hi_q, lo_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides everything, including acceptance.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = SQ_IDLE;
        end else begin
            case (state)
                SQ_IDLE: if (req_valid) state_nxt = (req_amt == '0) ? SQ_DONE : SQ_P0;
                SQ_P0:   state_nxt = amt_q[AW-1] ? SQ_DONE : SQ_P1;
                SQ_P1:   state_nxt = SQ_P2;
                SQ_P2:   state_nxt = SQ_DONE;
                SQ_DONE: if (resp_ready) state_nxt = SQ_IDLE;
                default: state_nxt = SQ_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        req_ready  = (state == SQ_IDLE);
        resp_valid = (state == SQ_DONE);
        resp_hi    = acc_hi;
        resp_lo    = acc_lo;
        sh_indata  = plan.indata;
        sh_num     = plan.num;
        sh_ctr     = plan.ctr;
        state_dbg  = state;
    end

    // Request capture and accumulation. A zero-amount request loads the
    // operand straight into the accumulators; otherwise they start cleared
    // and each pass ORs its result into the word chosen by the plan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            amt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (!flush) begin
            if (state == SQ_IDLE && req_valid) begin
                op_q   <= req_op;
                amt_q  <= req_amt;
                hi_q   <= req_hi;
                lo_q   <= req_lo;
                acc_hi <= (req_amt == '0) ? req_hi : '0;
                acc_lo <= (req_amt == '0) ? req_lo : '0;
            end else if (state == SQ_P0 || state == SQ_P1 || state == SQ_P2) begin
                if (plan.to_hi) begin
                    acc_hi <= acc_hi | sh_result;
                end else begin
                    acc_lo <= acc_lo | sh_result;
                end
                // Arithmetic right by 32..63 fills the upper word with the sign.
                if (state == SQ_P0 && amt_q[AW-1] && op_q == SH_ARIGHT) begin
                    acc_hi <= {DW{hi_q[DW-1]}};
                end
            end
        end
    end

endmodule

// File: tb/tb_shift64_seq.sv
// Bench for shift64_seq together with a behavioural 32-bit barrel shifter.
module tb_shift64_seq;
    import shift64_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [5:0]  req_amt = 6'd0;
    logic [31:0] req_hi = 32'h0;
    logic [31:0] req_lo = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_hi;
    logic [31:0] resp_lo;
    logic [31:0] sh_indata;
    logic [4:0]  sh_num;
    logic [1:0]  sh_ctr;
    logic [31:0] sh_result;
    sq_state_t   state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    shift64_seq dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_amt(req_amt), .req_hi(req_hi), .req_lo(req_lo),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hi(resp_hi), .resp_lo(resp_lo),
        .sh_indata(sh_indata), .sh_num(sh_num), .sh_ctr(sh_ctr),
        .sh_result(sh_result), .state_dbg(state_dbg)
    );

    // External shifter stand-in
    always_comb begin
        case (sh_ctr)
            2'b11:   sh_result = $signed(sh_indata) >>> sh_num;
            2'b10:   sh_result = sh_indata >> sh_num;
            default: sh_result = sh_indata << sh_num;
        endcase
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_shift(input logic [1:0] op, input logic [5:0] amt,
                                              input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] v;
        v = {hi, lo};
        if (!op[1])           return v << amt;
        else if (op == 2'b11) return $signed(v) >>> amt;
        else                  return v >> amt;
    endfunction

    function automatic int ref_lat(input logic [5:0] amt);
        if (amt == 6'd0) return 1;
        if (amt >= 6'd32) return 2;
        return 4;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          lat_q[$];
    bit          m_busy = 1'b0;
    int          m_age = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_age  = 0;
            exp_q.delete();
            lat_q.delete();
        end else if (flush) begin
            m_busy = 1'b0;
            exp_q.delete();
            lat_q.delete();
        end else if (m_busy) begin
            if (m_age >= lat_q[0] && resp_ready) begin
                m_busy = 1'b0;
                void'(exp_q.pop_front());
                void'(lat_q.pop_front());
            end else begin
                m_age++;
            end
        end else if (req_valid) begin
            m_busy = 1'b1;
            m_age  = 1;
            exp_q.push_back(ref_shift(req_op, req_amt, req_hi, req_lo));
            lat_q.push_back(ref_lat(req_amt));
        end
    end

    // Compare process: every cycle outside reset
    always @(negedge clk) begin
        bit done_exp;
        bit in_pass;
        if (rst_n) begin
            done_exp = m_busy && (m_age >= lat_q[0]);
            in_pass  = m_busy && (m_age < lat_q[0]);
            chk("req_ready", req_ready, !m_busy);
            chk("resp_valid", resp_valid, done_exp);
            if (done_exp) chk("resp_data", {resp_hi, resp_lo}, exp_q[0]);
            if (!in_pass) chk("sh_idle", {sh_indata, sh_num, sh_ctr}, 64'h0);
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic issue(input logic [1:0] op, input logic [5:0] amt,
                         input logic [31:0] hi, input logic [31:0] lo, output bit ok);
        req_valid = 1'b1;
        req_op = op; req_amt = amt; req_hi = hi; req_lo = lo;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 0, 1);
        else @(posedge clk);
        @(negedge clk);
        // Scramble request fields; the accepted request must be unaffected.
        req_valid = 1'b0;
        req_op = 2'($urandom); req_amt = 6'($urandom);
        req_hi = $urandom; req_lo = $urandom;
    endtask

    task automatic collect(input int hold, output int lat, output logic [63:0] got);
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) chk("resp_timeout", 0, 1);
        got = {resp_hi, resp_lo};
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [1:0] op, input logic [5:0] amt,
                            input logic [31:0] hi, input logic [31:0] lo,
                            input logic [63:0] exp, input int exp_lat);
        bit          ok;
        int          lat;
        logic [63:0] got;
        chk({name, "_model"}, ref_shift(op, amt, hi, lo), exp);
        issue(op, amt, hi, lo, ok);
        if (ok) begin
            collect(0, lat, got);
            chk({name, "_data"}, got, exp);
            chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit          ok;
        int          lat;
        logic [63:0] got;
        logic [1:0]  op;
        logic [5:0]  amt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [5:0]  edge_amts [6];
        edge_amts[0] = 6'd0;  edge_amts[1] = 6'd1;  edge_amts[2] = 6'd31;
        edge_amts[3] = 6'd32; edge_amts[4] = 6'd33; edge_amts[5] = 6'd63;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp", {resp_hi, resp_lo}, 64'h0);
        chk("rst_sh", {sh_indata, sh_num, sh_ctr}, 64'h0);
        chk("rst_state", state_dbg, SQ_IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        directed("t1_left4",   2'b00, 6'd4,  32'h00000001, 32'h80000000, 64'h00000018_00000000, 4);
        directed("t2_ar36",    2'b11, 6'd36, 32'h80000000, 32'h12345678, 64'hFFFFFFFF_F8000000, 2);
        directed("t3_lr8",     2'b10, 6'd8,  32'h11223344, 32'h55667788, 64'h00112233_44556677, 4);
        directed("t3_n0",      2'b10, 6'd0,  32'h11223344, 32'h55667788, 64'h11223344_55667788, 1);
        directed("t4_left63",  2'b01, 6'd63, 32'h00000000, 32'h00000001, 64'h80000000_00000000, 2);
        directed("t4_lr32",    2'b10, 6'd32, 32'hDEADBEEF, 32'h00000000, 64'h00000000_DEADBEEF, 2);
        directed("ar_small",   2'b11, 6'd4,  32'h80000000, 32'h0000000F, 64'hF8000000_00000000, 4);

        // Held response with a competing request
        issue(2'b00, 6'd4, 32'h00000001, 32'h80000000, ok);
        lat = 0;
        while (!resp_valid && lat < 12) begin @(negedge clk); lat++; end
        req_valid = 1'b1; req_op = 2'b10; req_amt = 6'd8;
        req_hi = 32'h11223344; req_lo = 32'h55667788;
        repeat (5) begin
            @(negedge clk);
            chk("t5_held_valid", resp_valid, 1);
            chk("t5_held_data", {resp_hi, resp_lo}, 64'h00000018_00000000);
            chk("t5_held_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("t5_ready_after", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        collect(0, lat, got);
        chk("t5_second_data", got, 64'h00112233_44556677);
        chk("t5_second_lat", 64'(lat), 64'd4);

        // Flush in P1
        issue(2'b00, 6'd4, 32'h00000001, 32'h80000000, ok);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t6_flush_ready", req_ready, 1);
        repeat (4) begin
            @(negedge clk);
            chk("t6_flush_noresp", resp_valid, 0);
        end
        // Flush beats a request in IDLE
        req_valid = 1'b1; req_op = 2'b00; req_amt = 6'd1;
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("t6_flush_req_ready", req_ready, 1);
        @(negedge clk);
        chk("t6_flush_req_noresp", resp_valid, 0);

        // Asynchronous reset during P0
        issue(2'b10, 6'd8, 32'h11223344, 32'h55667788, ok);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_arst_ready", req_ready, 1);
        chk("t6_arst_valid", resp_valid, 0);
        chk("t6_arst_sh", {sh_indata, sh_num, sh_ctr}, 64'h0);
        chk("t6_arst_resp", {resp_hi, resp_lo}, 64'h0);
        chk("t6_arst_state", state_dbg, SQ_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_arst_noresp", resp_valid, 0);

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            op  = 2'($urandom);
            amt = ($urandom_range(0, 3) == 0) ? edge_amts[$urandom_range(0, 5)] : 6'($urandom);
            hi  = $urandom;
            lo  = $urandom;
            issue(op, amt, hi, lo, ok);
            if (ok) begin
                collect(($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0, lat, got);
                chk("rand_data", got, ref_shift(op, amt, hi, lo));
                chk("rand_lat", 64'(lat), 64'(ref_lat(amt)));
            end
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
